// File: rtl/muldiv_issue_ctrl_pkg.sv
// Shared types for the execute-stage MUL/DIV sequencer.
// Operation encoding, FSM states and watchdog default.
package muldiv_issue_ctrl_pkg;

    localparam int DATA_SIZE      = 32;
    localparam int MULDIV_TIMEOUT = 64;

    typedef enum logic [2:0] {
        mul_inst,
        mulh_inst,
        mulhsu_inst,
        mulhu_inst,
        div_inst,
        divu_inst,
        rem_inst,
        remu_inst
    } muldiv_type;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        DRAIN
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_issue_ctrl_if.sv
// Start/done link between the MUL/DIV sequencer and the ALU.
// master = sequencer side, slave = ALU side.
interface muldiv_issue_ctrl_if
    import muldiv_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_SIZE
) ();

    logic [DATA_W-1:0] alu_a_o;
    logic [DATA_W-1:0] alu_b_o;
    muldiv_type        alu_op_o;
    logic              alu_valid_o;
    logic              alu_done_i;
    logic [DATA_W-1:0] alu_res_i;
    logic              alu_dbz_i;
    logic              alu_ovfl_i;

    modport master (
        output alu_a_o,
        output alu_b_o,
        output alu_op_o,
        output alu_valid_o,
        input  alu_done_i,
        input  alu_res_i,
        input  alu_dbz_i,
        input  alu_ovfl_i
    );

    modport slave (
        input  alu_a_o,
        input  alu_b_o,
        input  alu_op_o,
        input  alu_valid_o,
        output alu_done_i,
        output alu_res_i,
        output alu_dbz_i,
        output alu_ovfl_i
    );

endinterface

// File: rtl/muldiv_issue_ctrl_watchdog.sv
// Cycle counter guarding a hung multiplier/divider.
// Raises a one-cycle expire and a sticky timeout flag.
module muldiv_issue_ctrl_watchdog #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic clk,
    input  logic nrst,
    input  logic i_clear,
    input  logic i_run,
    input  logic i_done,
    output logic o_expire,
    output logic o_timeout
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    // A completion in the last allowed cycle still counts as on time.
    assign o_expire  = i_run & ~i_done & (r_cnt == CNT_W'(TIMEOUT - 1));
    assign o_timeout = r_timeout;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_run) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (o_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// EX-stage sequencer for multi-cycle M-extension ops.
// Latches operands, pulses the ALU, stalls until done.
module muldiv_issue_ctrl
    import muldiv_issue_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_SIZE,
    parameter int TIMEOUT = MULDIV_TIMEOUT,
    parameter int CNT_W   = 7
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              ex_valid_i,
    input  logic              is_muldiv_i,
    input  muldiv_type        muldiv_op_i,
    input  logic [DATA_W-1:0] rs1_i,
    input  logic [DATA_W-1:0] rs2_i,
    input  logic              flush_i,
    input  logic              wb_ready_i,
    muldiv_issue_ctrl_if.master alu,
    output logic              stall_o,
    output logic              res_valid_o,
    output logic [DATA_W-1:0] res_o,
    output logic              dbz_o,
    output logic              ovfl_o,
    output logic              timeout_o
);

    muldiv_state_t     r_state;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    muldiv_type        r_op;
    logic              r_alu_valid;
    logic              r_res_valid;
    logic [DATA_W-1:0] r_res;
    logic              r_dbz;
    logic              r_ovfl;

    logic w_start;
    logic w_busy;
    logic w_stall;
    logic w_expire;
    logic w_done;

    assign w_busy  = ex_valid_i & is_muldiv_i;
    assign w_start = w_busy & ~flush_i;
    assign w_done  = alu.alu_done_i;

    always_comb begin
        w_stall = 1'b0;
        unique case (r_state)
            IDLE:        w_stall = w_start;
            ISSUE, WAIT: w_stall = 1'b1;
            DONE:        w_stall = ~wb_ready_i;
            DRAIN:       w_stall = w_busy;
            default:     w_stall = 1'b0;
        endcase
    end

    // Reset must force stall low even while EX still holds a muldiv.
    assign stall_o = nrst & w_stall;

    muldiv_issue_ctrl_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk       (clk),
        .nrst      (nrst),
        .i_clear   (r_state == ISSUE),
        .i_run     ((r_state == WAIT) || (r_state == DRAIN)),
        .i_done    (w_done),
        .o_expire  (w_expire),
        .o_timeout (timeout_o)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= mul_inst;
            r_alu_valid <= 1'b0;
            r_res_valid <= 1'b0;
            r_res       <= '0;
            r_dbz       <= 1'b0;
            r_ovfl      <= 1'b0;
        end else begin
            r_alu_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_a         <= rs1_i;
                        r_b         <= rs2_i;
                        r_op        <= muldiv_op_i;
                        r_alu_valid <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_state <= flush_i ? DRAIN : WAIT;
                end
                WAIT: begin
                    if (w_done && flush_i) begin
                        r_state <= IDLE;
                    end else if (w_done) begin
                        r_res       <= alu.alu_res_i;
                        r_dbz       <= alu.alu_dbz_i;
                        r_ovfl      <= alu.alu_ovfl_i;
                        r_res_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (w_expire) begin
                        r_state <= IDLE;
                    end else if (flush_i) begin
                        r_state <= DRAIN;
                    end
                end
                DONE: begin
                    if (wb_ready_i || flush_i) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                DRAIN: begin
                    if (w_done || w_expire) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign alu.alu_a_o     = r_a;
    assign alu.alu_b_o     = r_b;
    assign alu.alu_op_o    = r_op;
    assign alu.alu_valid_o = r_alu_valid;
    assign res_valid_o     = r_res_valid;
    assign res_o           = r_res;
    assign dbz_o           = r_dbz;
    assign ovfl_o          = r_ovfl;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed bench: behavioural ALU plus result scoreboard
// for the MUL/DIV issue sequencer.
module tb_muldiv_issue_ctrl;
    import muldiv_issue_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        nrst;
    logic        ex_valid_i;
    logic        is_muldiv_i;
    muldiv_type  muldiv_op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        flush_i;
    logic        wb_ready_i;
    logic        stall_o;
    logic        res_valid_o;
    logic [31:0] res_o;
    logic        dbz_o;
    logic        ovfl_o;
    logic        timeout_o;

    int n_chk  = 0;
    int n_pass = 0;
    int alu_lat = 3;

    logic [33:0] exp_q[$];

    muldiv_issue_ctrl_if #(.DATA_W(32)) alu_bus ();

    muldiv_issue_ctrl #(
        .DATA_W  (32),
        .TIMEOUT (64),
        .CNT_W   (7)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .ex_valid_i  (ex_valid_i),
        .is_muldiv_i (is_muldiv_i),
        .muldiv_op_i (muldiv_op_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .flush_i     (flush_i),
        .wb_ready_i  (wb_ready_i),
        .alu         (alu_bus.master),
        .stall_o     (stall_o),
        .res_valid_o (res_valid_o),
        .res_o       (res_o),
        .dbz_o       (dbz_o),
        .ovfl_o      (ovfl_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk = ~clk;

    // RISC-V M-extension reference: {dbz, ovfl, result}
    function automatic logic [33:0] model(muldiv_type op,
                                          logic [31:0] a,
                                          logic [31:0] b);
        logic [63:0] p;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        logic        sov;
        dz  = 1'b0;
        ov  = 1'b0;
        r   = '0;
        sov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            mul_inst: begin
                p = 64'($signed(a)) * 64'($signed(b));
                r = p[31:0];
            end
            mulh_inst: begin
                p = 64'($signed(a)) * 64'($signed(b));
                r = p[63:32];
            end
            mulhsu_inst: begin
                p = 64'($signed(a)) * {32'd0, b};
                r = p[63:32];
            end
            mulhu_inst: begin
                p = {32'd0, a} * {32'd0, b};
                r = p[63:32];
            end
            div_inst: begin
                if (b == 0) begin r = '1; dz = 1'b1; end
                else if (sov) begin r = a; ov = 1'b1; end
                else r = $signed(a) / $signed(b);
            end
            divu_inst: begin
                if (b == 0) begin r = '1; dz = 1'b1; end
                else r = a / b;
            end
            rem_inst: begin
                if (b == 0) begin r = a; dz = 1'b1; end
                else if (sov) begin r = '0; ov = 1'b1; end
                else r = $signed(a) % $signed(b);
            end
            default: begin
                if (b == 0) begin r = a; dz = 1'b1; end
                else r = a % b;
            end
        endcase
        return {dz, ov, r};
    endfunction

    // Behavioural ALU: done alu_lat cycles after the start pulse; 0 = hang.
    int          alu_cd;
    logic [33:0] alu_out;
    always @(negedge clk or negedge nrst) begin
        if (!nrst) begin
            alu_cd = 0;
            alu_out = '0;
            alu_bus.alu_done_i = 1'b0;
            alu_bus.alu_res_i  = '0;
            alu_bus.alu_dbz_i  = 1'b0;
            alu_bus.alu_ovfl_i = 1'b0;
        end else begin
            alu_bus.alu_done_i = 1'b0;
            if (alu_bus.alu_valid_o) begin
                alu_cd  = alu_lat;
                alu_out = model(alu_bus.alu_op_o, alu_bus.alu_a_o,
                                alu_bus.alu_b_o);
            end else if (alu_cd > 0) begin
                alu_cd = alu_cd - 1;
                alu_bus.alu_done_i = (alu_cd == 0);
            end
            {alu_bus.alu_dbz_i, alu_bus.alu_ovfl_i, alu_bus.alu_res_i} =
                alu_bus.alu_done_i ? alu_out : 34'd0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Issue one muldiv and retire it; wb_ready held low for wb_hold DONE cycles.
    task automatic do_op(input string tag, input muldiv_type op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int wb_hold);
        int          n_stall;
        int          n_vld;
        int          hold;
        logic        got;
        logic [33:0] e;
        n_stall = 0;
        n_vld   = 0;
        hold    = 0;
        got     = 1'b0;
        alu_lat = lat;
        exp_q.push_back(model(op, a, b));
        ex_valid_i  = 1'b1;
        is_muldiv_i = 1'b1;
        muldiv_op_i = op;
        rs1_i       = a;
        rs2_i       = b;
        for (int c = 0; c < 300 && !got; c++) begin
            wb_ready_i = (hold >= wb_hold);
            #1;
            if (stall_o) n_stall++;
            if (alu_bus.alu_valid_o) n_vld++;
            if (res_valid_o && exp_q.size() > 0) begin
                e = exp_q[0];
                if (!wb_ready_i) begin
                    hold++;
                    chk({tag, "_hold_stall"}, 64'(stall_o), 64'd1);
                    chk({tag, "_hold_res"}, 64'(res_o), 64'(e[31:0]));
                end else begin
                    got = 1'b1;
                    e = exp_q.pop_front();
                    chk({tag, "_res"}, 64'(res_o), 64'(e[31:0]));
                    chk({tag, "_dbz"}, 64'(dbz_o), 64'(e[33]));
                    chk({tag, "_ovfl"}, 64'(ovfl_o), 64'(e[32]));
                end
            end
            @(negedge clk);
        end
        chk({tag, "_accepted"}, 64'(got), 64'd1);
        ex_valid_i  = 1'b0;
        is_muldiv_i = 1'b0;
        #1;
        chk({tag, "_resv_drop"}, 64'(res_valid_o), 64'd0);
        chk({tag, "_pulses"}, 64'(n_vld), 64'd1);
        chk({tag, "_stall_cyc"}, 64'(n_stall), 64'(lat + 2 + wb_hold));
        @(negedge clk);
    endtask

    initial begin
        int   n_stall;
        logic seen;
        nrst        = 1'b0;
        ex_valid_i  = 1'b0;
        is_muldiv_i = 1'b0;
        muldiv_op_i = mul_inst;
        rs1_i       = '0;
        rs2_i       = '0;
        flush_i     = 1'b0;
        wb_ready_i  = 1'b1;
        #1;
        chk("rst_flags", 64'({stall_o, res_valid_o, dbz_o, ovfl_o,
            timeout_o, alu_bus.alu_valid_o}), 64'd0);
        chk("rst_op", 64'(alu_bus.alu_op_o), 64'(mul_inst));
        chk("rst_res", 64'(res_o), 64'd0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        ex_valid_i = 1'b1;
        #1;
        chk("nonmd_nostall", 64'(stall_o), 64'd0);
        ex_valid_i = 1'b0;
        @(negedge clk);

        do_op("mul", mul_inst, 32'd7, 32'd6, 3, 0);
        do_op("div0", div_inst, 32'd100, 32'd0, 5, 0);
        do_op("divov", div_inst, 32'h8000_0000, 32'hFFFF_FFFF, 4, 0);

        // REMU killed in its second WAIT cycle
        alu_lat     = 6;
        ex_valid_i  = 1'b1;
        is_muldiv_i = 1'b1;
        muldiv_op_i = remu_inst;
        rs1_i       = 32'd55;
        rs2_i       = 32'd9;
        #1;
        chk("fl_idle_stall", 64'(stall_o), 64'd1);
        @(negedge clk);
        #1;
        chk("fl_issue_pulse", 64'(alu_bus.alu_valid_o), 64'd1);
        @(negedge clk);
        @(negedge clk);
        flush_i    = 1'b1;
        ex_valid_i = 1'b0;
        #1;
        chk("fl_wait_stall", 64'(stall_o), 64'd1);
        @(negedge clk);
        flush_i     = 1'b0;
        ex_valid_i  = 1'b1;
        is_muldiv_i = 1'b0;
        #1;
        chk("drain_add_stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        is_muldiv_i = 1'b1;
        #1;
        chk("drain_md_stall", 64'(stall_o), 64'd1);
        is_muldiv_i = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (res_valid_o) seen = 1'b1;
        end
        chk("drain_no_res", 64'(seen), 64'd0);
        ex_valid_i = 1'b0;
        @(negedge clk);

        do_op("mulhu", mulhu_inst, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0);
        do_op("divu_bp", divu_inst, 32'd1000, 32'd7, 4, 4);

        // Hung ALU: watchdog fires after 64 WAIT cycles
        alu_lat     = 0;
        wb_ready_i  = 1'b1;
        ex_valid_i  = 1'b1;
        is_muldiv_i = 1'b1;
        muldiv_op_i = div_inst;
        rs1_i       = 32'd9;
        rs2_i       = 32'd3;
        n_stall     = 0;
        seen        = 1'b0;
        for (int c = 0; c < 200 && !timeout_o; c++) begin
            #1;
            if (res_valid_o) seen = 1'b1;
            if (!timeout_o) begin
                if (stall_o) n_stall++;
                @(negedge clk);
            end
        end
        chk("wd_timeout", 64'(timeout_o), 64'd1);
        chk("wd_stall_cyc", 64'(n_stall), 64'd66);
        ex_valid_i  = 1'b0;
        is_muldiv_i = 1'b0;
        #1;
        chk("wd_release", 64'(stall_o), 64'd0);
        chk("wd_no_res", 64'({seen, res_valid_o}), 64'd0);

        // Asynchronous reset in the middle of WAIT
        @(negedge clk);
        ex_valid_i  = 1'b1;
        is_muldiv_i = 1'b1;
        muldiv_op_i = mulh_inst;
        rs1_i       = 32'd3;
        rs2_i       = 32'd5;
        repeat (4) @(negedge clk);
        #2;
        chk("pre_rst_stall", 64'(stall_o), 64'd1);
        chk("pre_rst_sticky", 64'(timeout_o), 64'd1);
        nrst = 1'b0;
        #1;
        chk("arst_flags", 64'({stall_o, res_valid_o, dbz_o, ovfl_o,
            timeout_o, alu_bus.alu_valid_o}), 64'd0);
        chk("arst_res", 64'(res_o), 64'd0);
        chk("arst_ops", 64'({alu_bus.alu_a_o, alu_bus.alu_b_o}), 64'd0);
        chk("arst_op", 64'(alu_bus.alu_op_o), 64'(mul_inst));
        ex_valid_i  = 1'b0;
        is_muldiv_i = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        do_op("mul_post", mul_inst, 32'hFFFF_FFFD, 32'd4, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
